// File: rtl/ad7864_multich_p2s.sv
// Reads NCH words from the AD7864 parallel bus on each db_rdy rising edge and
// streams them to a McBSP receiver as one framed serial burst.
module ad7864_multich_p2s #(
  parameter int NCH       = 4,
  parameter int DW        = 12,
  parameter int RD_LOW    = 2,
  parameter int RD_HIGH   = 1,
  parameter int SCLK_DIV  = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clkin,
  input  logic          rst_bar,
  input  logic          db_rdy,
  input  logic [DW-1:0] db,
  output logic          cs_bar,
  output logic          rd_bar,
  output logic          sclk,
  output logic          sdata,
  output logic          fsync,
  output logic          busy,
  output logic          overrun
);

  localparam int NB   = NCH * DW;
  localparam int BW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int RMAX = (RD_LOW > RD_HIGH) ? RD_LOW : RD_HIGH;
  localparam int CMAX = (RMAX > 2 * SCLK_DIV) ? RMAX : 2 * SCLK_DIV;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0]  RD_LO_LAST = CW'(RD_LOW - 1);
  localparam logic [CW-1:0]  RD_HI_LAST = CW'(RD_HIGH - 1);
  localparam logic [CW-1:0]  HALF_LAST  = CW'(SCLK_DIV - 1);
  localparam logic [CW-1:0]  PER_LAST   = CW'(2 * SCLK_DIV - 1);
  localparam logic [CHW-1:0] CH_LAST    = CHW'(NCH - 1);
  localparam logic [BW-1:0]  BIT_LAST   = BW'(NB - 1);

  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, SHIFT} state_t;

  state_t          state_q, state_d;
  logic            db_rdy_q;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [NB-1:0]   buf_q, buf_d;
  logic [NB-1:0]   sreg_q, sreg_d;
  logic [NB-1:0]   stream;
  logic            cs_bar_q, cs_bar_d;
  logic            rd_bar_q, rd_bar_d;
  logic            sclk_q, sclk_d;
  logic            sdata_q, sdata_d;
  logic            fsync_q, fsync_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;
  logic            start;
  logic            capture;

  assign start   = db_rdy & ~db_rdy_q;
  assign capture = (state_q == RD_LO) && (cnt_q == '0);

  always_comb begin
    buf_d = buf_q;
    if (capture) begin
      buf_d[int'(ch_q) * DW +: DW] = db;
    end
  end

  // Reorder the buffer into transmission order so bit 0 of stream goes out first.
  // Built from buf_d so the word captured on the SHIFT entry edge is included.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_word
    for (genvar gj = 0; gj < DW; gj++) begin : g_bit
      assign stream[gi * DW + gj] = MSB_FIRST ? buf_d[gi * DW + DW - 1 - gj]
                                              : buf_d[gi * DW + gj];
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sreg_d    = sreg_q;
    cs_bar_d  = cs_bar_q;
    rd_bar_d  = rd_bar_q;
    sclk_d    = sclk_q;
    sdata_d   = sdata_q;
    fsync_d   = fsync_q;
    busy_d    = busy_q;
    overrun_d = start && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RD_LO;
          cs_bar_d = 1'b0;
          rd_bar_d = 1'b0;
          busy_d   = 1'b1;
          ch_d     = '0;
          cnt_d    = RD_LO_LAST;
        end
      end
      RD_LO: begin
        if (cnt_q == '0) begin
          rd_bar_d = 1'b1;
          if (ch_q == CH_LAST) begin
            // Entry edge of SHIFT is also the rising sclk edge of bit 0.
            state_d  = SHIFT;
            cs_bar_d = 1'b1;
            cnt_d    = '0;
            bit_d    = '0;
            sclk_d   = 1'b1;
            sdata_d  = stream[0];
            fsync_d  = 1'b1;
            sreg_d   = stream >> 1;
          end else begin
            state_d = RD_HI;
            cnt_d   = RD_HI_LAST;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RD_HI: begin
        if (cnt_q == '0) begin
          state_d  = RD_LO;
          ch_d     = ch_q + CHW'(1);
          rd_bar_d = 1'b0;
          cnt_d    = RD_LO_LAST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SHIFT: begin
        if (cnt_q == PER_LAST) begin
          cnt_d   = '0;
          fsync_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            state_d = IDLE;
            sclk_d  = 1'b0;
            sdata_d = 1'b0;
            busy_d  = 1'b0;
          end else begin
            bit_d   = bit_q + BW'(1);
            sclk_d  = 1'b1;
            sdata_d = sreg_q[0];
            sreg_d  = sreg_q >> 1;
          end
        end else begin
          if (cnt_q == HALF_LAST) begin
            sclk_d = 1'b0;
          end
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkin or negedge rst_bar) begin
    if (!rst_bar) begin
      state_q   <= IDLE;
      db_rdy_q  <= 1'b0;
      ch_q      <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      buf_q     <= '0;
      sreg_q    <= '0;
      cs_bar_q  <= 1'b1;
      rd_bar_q  <= 1'b1;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      fsync_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      db_rdy_q  <= db_rdy;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      buf_q     <= buf_d;
      sreg_q    <= sreg_d;
      cs_bar_q  <= cs_bar_d;
      rd_bar_q  <= rd_bar_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      fsync_q   <= fsync_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign cs_bar  = cs_bar_q;
  assign rd_bar  = rd_bar_q;
  assign sclk    = sclk_q;
  assign sdata   = sdata_q;
  assign fsync   = fsync_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_ad7864_multich_p2s.sv
// Bench for ad7864_multich_p2s: two instances (default timing, and a 2-channel
// LSB-first fast-sclk variant) checked every cycle against a frame-timeline model.
module tb_ad7864_multich_p2s;

  logic        clk;
  logic        rst_bar;
  logic        rdy_a, rdy_b;
  logic [11:0] db_a, db_b;
  logic        cs_a, rd_a, sclk_a, sd_a, fs_a, busy_a, ov_a;
  logic        cs_b, rd_b, sclk_b, sd_b, fs_b, busy_b, ov_b;

  ad7864_multich_p2s dut_a (
    .clkin(clk), .rst_bar(rst_bar), .db_rdy(rdy_a), .db(db_a),
    .cs_bar(cs_a), .rd_bar(rd_a), .sclk(sclk_a), .sdata(sd_a),
    .fsync(fs_a), .busy(busy_a), .overrun(ov_a)
  );

  ad7864_multich_p2s #(
    .NCH(2), .DW(12), .RD_LOW(4), .RD_HIGH(3), .SCLK_DIV(1), .MSB_FIRST(1'b0)
  ) dut_b (
    .clkin(clk), .rst_bar(rst_bar), .db_rdy(rdy_b), .db(db_b),
    .cs_bar(cs_b), .rd_bar(rd_b), .sclk(sclk_b), .sdata(sd_b),
    .fsync(fs_b), .busy(busy_b), .overrun(ov_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout: {cs_bar, rd_bar, sclk, sdata, fsync, busy, overrun}
  localparam logic [6:0] RST_OUT = 7'b1100000;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model state per instance
  logic        m_prev [2];
  logic        m_act  [2];
  logic        m_ovr  [2];
  int          m_k    [2];
  logic [11:0] m_words[2][4];

  // Output monitors per instance (cumulative)
  int          mon_cs  [2];
  int          mon_rdf [2];
  int          mon_sclr[2];
  int          mon_fs  [2];
  int          mon_ov  [2];
  logic [63:0] mon_str [2];
  logic [6:0]  mon_prev[2];

  function automatic int p_nch(int i); return (i == 0) ? 4 : 2; endfunction
  function automatic int p_rl (int i); return (i == 0) ? 2 : 4; endfunction
  function automatic int p_rh (int i); return (i == 0) ? 1 : 3; endfunction
  function automatic int p_s  (int i); return (i == 0) ? 2 : 1; endfunction
  function automatic bit p_msb(int i); return (i == 0); endfunction

  function automatic logic [6:0] dut_out(int i);
    if (i == 0) return {cs_a, rd_a, sclk_a, sd_a, fs_a, busy_a, ov_a};
    return {cs_b, rd_b, sclk_b, sd_b, fs_b, busy_b, ov_b};
  endfunction

  // Frame timeline: cycle k of an accepted frame (k=0 is the cycle after the
  // accepting edge) fully determines every output.
  function automatic logic [6:0] exp_out(int i);
    int   per, rlen, sh, b, ph, w, j;
    logic bv;
    per  = p_rl(i) + p_rh(i);
    rlen = p_nch(i) * p_rl(i) + (p_nch(i) - 1) * p_rh(i);
    if (!m_act[i]) return {6'b110000, m_ovr[i]};
    if (m_k[i] < rlen)
      return {1'b0, ((m_k[i] % per) < p_rl(i)) ? 1'b0 : 1'b1, 3'b000, 1'b1, m_ovr[i]};
    sh = m_k[i] - rlen;
    b  = sh / (2 * p_s(i));
    ph = sh % (2 * p_s(i));
    w  = b / 12;
    j  = b % 12;
    bv = p_msb(i) ? m_words[i][w][11 - j] : m_words[i][w][j];
    return {2'b11, (ph < p_s(i)), bv, (b == 0), 1'b1, m_ovr[i]};
  endfunction

  task automatic model_step(int i, logic rs, logic r, logic [11:0] d);
    int   per, rlen, total;
    logic st;
    per   = p_rl(i) + p_rh(i);
    rlen  = p_nch(i) * p_rl(i) + (p_nch(i) - 1) * p_rh(i);
    total = rlen + p_nch(i) * 12 * 2 * p_s(i);
    if (!rs) begin
      m_prev[i] = 1'b0; m_act[i] = 1'b0; m_ovr[i] = 1'b0; m_k[i] = 0;
      for (int c = 0; c < 4; c++) m_words[i][c] = '0;
      return;
    end
    st        = r && !m_prev[i];
    m_prev[i] = r;
    m_ovr[i]  = st && m_act[i];
    if (m_act[i]) begin
      if (m_k[i] < rlen && (m_k[i] % per) == p_rl(i) - 1) m_words[i][m_k[i] / per] = d;
      m_k[i]++;
      if (m_k[i] == total) m_act[i] = 1'b0;
    end else if (st) begin
      m_act[i] = 1'b1;
      m_k[i]   = 0;
    end
  endtask

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // One clock: sample inputs at the edge, check outputs 1 time unit later,
  // update monitors, return on the following falling edge.
  task automatic tick();
    logic        rs, ra, rb;
    logic [11:0] da, dbv;
    logic [6:0]  o;
    @(posedge clk);
    rs = rst_bar; ra = rdy_a; rb = rdy_b; da = db_a; dbv = db_b;
    #1;
    cyc++;
    model_step(0, rs, ra, da);
    model_step(1, rs, rb, dbv);
    for (int i = 0; i < 2; i++) begin
      o = dut_out(i);
      chk($sformatf("cycle%0d_inst%0d_outs", cyc, i), 64'(o), 64'(exp_out(i)));
      if (!o[6]) mon_cs[i]++;
      if (mon_prev[i][5] && !o[5]) mon_rdf[i]++;
      if (!mon_prev[i][4] && o[4]) mon_sclr[i]++;
      if (mon_prev[i][4] && !o[4]) mon_str[i] = {mon_str[i][62:0], o[3]};
      if (o[2]) mon_fs[i]++;
      if (o[0]) mon_ov[i]++;
      mon_prev[i] = o;
    end
    @(negedge clk);
  endtask

  // Default-instance frame with db stepping through a table at each read.
  task automatic frame_a_tbl();
    logic [11:0] tbl [4];
    int          idx;
    tbl[0] = 12'hA5C; tbl[1] = 12'h3F0; tbl[2] = 12'h001; tbl[3] = 12'hFFF;
    rdy_a = 1'b1; db_a = tbl[0];
    tick();
    for (int k = 0; k < 208; k++) begin
      idx  = (k / 3 > 3) ? 3 : k / 3;
      db_a = tbl[idx];
      if (k == 2) rdy_a = 1'b0;
      tick();
    end
  endtask

  int b_cs, b_rdf, b_scl, b_fs, b_ov;

  task automatic snap(int i);
    b_cs = mon_cs[i]; b_rdf = mon_rdf[i]; b_scl = mon_sclr[i];
    b_fs = mon_fs[i]; b_ov = mon_ov[i];
  endtask

  initial begin
    rst_bar = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0; db_a = '0; db_b = '0;
    for (int i = 0; i < 2; i++) begin
      mon_cs[i] = 0; mon_rdf[i] = 0; mon_sclr[i] = 0; mon_fs[i] = 0; mon_ov[i] = 0;
      mon_str[i] = '0; mon_prev[i] = RST_OUT;
      m_prev[i] = 1'b0; m_act[i] = 1'b0; m_ovr[i] = 1'b0; m_k[i] = 0;
    end
    @(negedge clk);
    repeat (3) tick();
    chk("reset_outs_a", 64'(dut_out(0)), 64'(RST_OUT));
    chk("reset_outs_b", 64'(dut_out(1)), 64'(RST_OUT));
    rst_bar = 1'b1;
    repeat (3) tick();

    // Single default frame
    snap(0);
    frame_a_tbl();
    chk("A_cs_low_cycles", 64'(mon_cs[0] - b_cs), 64'd11);
    chk("A_rd_pulses", 64'(mon_rdf[0] - b_rdf), 64'd4);
    chk("A_sclk_periods", 64'(mon_sclr[0] - b_scl), 64'd48);
    chk("A_fsync_cycles", 64'(mon_fs[0] - b_fs), 64'd4);
    chk("A_stream", 64'(mon_str[0][47:0]), 64'h0000_A5C3_F000_1FFF);
    chk("A_busy_after", 64'(busy_a), 64'd0);

    // LSB-first two-channel instance with fast sclk
    snap(1);
    rdy_b = 1'b1; db_b = 12'h801;
    tick();
    for (int k = 0; k < 70; k++) begin
      if (k == 2) rdy_b = 1'b0;
      tick();
    end
    chk("B_cs_low_cycles", 64'(mon_cs[1] - b_cs), 64'd11);
    chk("B_rd_pulses", 64'(mon_rdf[1] - b_rdf), 64'd2);
    chk("B_sclk_periods", 64'(mon_sclr[1] - b_scl), 64'd24);
    chk("B_fsync_cycles", 64'(mon_fs[1] - b_fs), 64'd2);
    chk("B_stream_lsb_first", 64'(mon_str[1][23:0]), 64'h801801);

    // Overrun 100 cycles into SHIFT, then db_rdy held high across two frames
    snap(0);
    rdy_a = 1'b1; db_a = 12'h5A5;
    tick();
    for (int k = 0; k < 203 + 406; k++) begin
      if (k == 2) rdy_a = 1'b0;
      if (k == 111) rdy_a = 1'b1;
      db_a = 12'($urandom);
      tick();
    end
    chk("overrun_pulses", 64'(mon_ov[0] - b_ov), 64'd1);
    chk("overrun_rd_pulses", 64'(mon_rdf[0] - b_rdf), 64'd4);
    chk("level_hold_sclk", 64'(mon_sclr[0] - b_scl), 64'd48);
    rdy_a = 1'b0;
    tick();
    rdy_a = 1'b1;
    for (int k = 0; k < 210; k++) tick();
    rdy_a = 1'b0;
    tick();
    chk("retrigger_rd_pulses", 64'(mon_rdf[0] - b_rdf), 64'd8);
    chk("retrigger_sclk", 64'(mon_sclr[0] - b_scl), 64'd96);

    // Reset during the 20th bit, then a fresh frame
    rdy_a = 1'b1; db_a = 12'h777;
    tick();
    for (int k = 0; k < 89; k++) begin
      if (k == 2) rdy_a = 1'b0;
      tick();
    end
    rst_bar = 1'b0;
    #1;
    chk("midshift_reset_outs", 64'(dut_out(0)), 64'(RST_OUT));
    repeat (3) tick();
    rst_bar = 1'b1;
    snap(0);
    repeat (50) tick();
    chk("post_reset_no_sclk", 64'(mon_sclr[0] - b_scl), 64'd0);
    frame_a_tbl();
    chk("fresh_frame_sclk", 64'(mon_sclr[0] - b_scl), 64'd48);
    chk("fresh_frame_stream", 64'(mon_str[0][47:0]), 64'h0000_A5C3_F000_1FFF);

    // Randomised traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) rdy_a = ~rdy_a;
      if ($urandom_range(0, 29) == 0) rdy_b = ~rdy_b;
      db_a    = 12'($urandom);
      db_b    = 12'($urandom);
      rst_bar = ($urandom_range(0, 1499) != 0);
      tick();
    end
    rst_bar = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ad7864_multich_p2s.md
Name: ad7864_multich_p2s

Overview:
- Parametrised successor to the single-word parallel-to-serial path behind the AD7864 driver.
- On each conversion-ready event it reads NCH channel words from the ADC parallel bus using timed cs_bar/rd_bar strobes and buffers them.
- It then streams all words to the DSP serial port as one framed burst: sclk, sdata and a one-bit-period fsync.
- It sits between ad7864Drv (db_rdy) and the TMS320VC5509A McBSP receive pins, and flags conversions that arrive while a frame is still in progress.

Parameters:
- NCH, 4, channels read per conversion (1..4).
- DW, 12, ADC word width in bits (1..16).
- RD_LOW, 2, clkin cycles rd_bar is held low per read (>=1).
- RD_HIGH, 1, clkin cycles rd_bar is held high between reads (>=1).
- SCLK_DIV, 2, clkin cycles per sclk half-period (>=1).
- MSB_FIRST, 1, 1 = MSB of each word shifted first; 0 = LSB first.

Ports:
- clkin  in  1  system clock; all logic on its rising edge.
- rst_bar  in  1  asynchronous active-low reset.
- db_rdy  in  1  conversion-complete level from ad7864Drv; rising edge starts a read sequence.
- db  in  DW  ADC parallel data bus.
- cs_bar  out  1  ADC chip select, active low.
- rd_bar  out  1  ADC read strobe, active low.
- sclk  out  1  serial bit clock to DSP.
- sdata  out  1  serial data to DSP.
- fsync  out  1  frame sync, high during the first bit period of a frame.
- busy  out  1  high from the cycle after a start edge until the frame completes.
- overrun  out  1  one-cycle pulse when a start edge arrives while busy.

Behaviour:
- Reset (async on rst_bar=0):
  - Outputs: cs_bar=1, rd_bar=1, sclk=0, sdata=0, fsync=0, busy=0, overrun=0.
  - Internal: state=IDLE, all counters and the word buffer cleared, db_rdy edge register cleared.
  - A reset asserted mid-read or mid-shift aborts the frame; no partial frame resumes after reset release.
- Start detect: start = db_rdy & ~db_rdy_q, with db_rdy_q registered every cycle.
  - Acted on only in IDLE.
  - In any other state, start pulses overrun for 1 cycle and is otherwise ignored.
- States: IDLE, RD_LO, RD_HI, SHIFT.
- IDLE -> RD_LO on start.
  - On the next edge: cs_bar=0, rd_bar=0, busy=1, ch=0, cycle counter loaded.
- RD_LO lasts RD_LOW cycles.
  - At the edge ending the last RD_LO cycle: db is captured into buf[ch] and rd_bar=1.
  - If ch<NCH-1: go to RD_HI.
  - If ch==NCH-1: cs_bar=1 and go to SHIFT.
- RD_HI lasts RD_HIGH cycles (cs_bar stays 0), then returns to RD_LO with ch+1 and rd_bar=0.
- Read-phase length: NCH*RD_LOW + (NCH-1)*RD_HIGH cycles with cs_bar low.
- SHIFT:
  - Bit order: buf[0] first, then buf[1]..buf[NCH-1]; within each word, order is set by MSB_FIRST.
  - Total bits per frame: NCH*DW.
  - Each bit period is 2*SCLK_DIV cycles. sclk=1 for the first SCLK_DIV cycles and 0 for the rest.
  - sdata and fsync change only on the edge where sclk rises, so they are stable on the sclk falling edge, where the DSP samples.
  - fsync=1 exactly during bit 0's period, 0 otherwise.
  - After the last bit period: sclk=0, sdata=0, busy=0, state=IDLE.
  - The earliest next start is accepted on the first IDLE cycle.
- Frame duration: NCH*DW*2*SCLK_DIV cycles.
- Width rules:
  - Bit counter is wide enough for NCH*DW-1 with no wrap inside a frame.
  - ch and cycle counters are sized from their parameters.
  - Buffer is NCH*DW bits.
- Simultaneous events:
  - start on the same cycle SHIFT finishes counts as busy: overrun pulses and the start is ignored.
  - db_rdy held high never retriggers; a new 0->1 transition is required.
- db is sampled only at the RD_LO capture edges; changes at any other time have no effect.

Test Plan:
- Reset mid-SHIFT: assert rst_bar=0 during the 20th bit -> all outputs return to reset values immediately, no sclk edges occur after release, and the next db_rdy edge produces a complete, fresh 48-bit frame.
- Single frame (defaults NCH=4, DW=12, RD_LOW=2, RD_HIGH=1, SCLK_DIV=2), db stepping through 12'hA5C, 12'h3F0, 12'h001, 12'hFFF at each read, one db_rdy rise:
  - cs_bar low 11 cycles with 4 rd_bar low pulses of 2 cycles each.
  - Then 48 sclk periods of 4 cycles each (192 cycles).
  - Sampled stream is A5C 3F0 001 FFF, MSB first.
  - fsync high only for the first 4 cycles of SHIFT.
  - busy low afterwards.
- MSB_FIRST=0, NCH=1, DW=12, db=12'h801 -> 12 bits sampled are 1,0,0,0,0,0,0,0,0,0,0,1 (LSB first), and fsync coincides with the first bit.
- Overrun: second db_rdy rise 100 cycles into SHIFT -> overrun is a 1-cycle pulse, the current frame completes unchanged, and no new read strobes occur.
- Level hold: db_rdy held high across two frame durations -> exactly one frame is produced; a toggle low then high triggers a second frame.
- Timing sweep: RD_LOW=4, RD_HIGH=3, SCLK_DIV=1, NCH=2 -> rd_bar pulses are 4 cycles low with a 3-cycle gap, cs_bar is low 11 cycles, and sclk period is 2 cycles for 24 bits.
